mem_atomic_master: RTL and testbench
====================================

# mem_atomic_master

- Wishbone initiator that issues CPU data-memory requests, including RV32A atomics, toward the tagged RAM bus.
- Converts one request from the execute stage into one Wishbone transaction, or two for AMO (read, then write). Drives the address tag that the RAM bus uses for its reservation, and reports results:
  - the loaded value;
  - SC success (0) or failure (1);
  - the AMO old value.
- Sits between the execute/memory stage and the RAM-bus slave port.

## Interface
Parameters:
- CLK_PERIOD_NS, 20, system clock period; for documentation and timeout scaling only.
- TIMEOUT_CYCLES, 1024, cycles `stb_o` may stay high without `ack_i`. Used only with `MEM_ATOMIC_TIMEOUT_EN`.

Ports. Clock is `clk_i`; reset is `rst_i`, synchronous, active-high.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block idle, accepts request
- req_kind_i  in  2  0 load, 1 store, 2 atomic
- req_funct5_i  in  5  RV32A funct5; used only when kind=2
- req_addr_i  in  32  byte address
- req_sel_i  in  4  byte select for load/store (0001, 0011, 1111)
- req_data_i  in  32  store data / rs2
- rsp_valid_o  out  1  one-cycle result pulse
- rsp_data_o  out  32  result
- rsp_err_o  out  1  misaligned atomic or bus timeout
- stb_o, cyc_o, we_o  out  1 each  Wishbone master controls
- sel_o  out  4  byte select
- addr_o  out  32  address
- addr_tag_o  out  `ADDR_TAG_BITS`  NONE / MODE_LRSC / MODE_AMO
- data_o  out  32  write data
- ack_i  in  1  slave ack; may be combinational from `stb_o`
- data_i  in  32  read data
- data_tag_i  in  1  SC reservation failed; valid with `ack_i`

## Operation
States: IDLE, READ, WRITE, AMO_GAP, RESP.

**IDLE**
- `req_ready_o=1`. A request is accepted on `req_valid_i & req_ready_o`, and its fields are registered.
- Atomic with `addr[1:0]!=0`: no bus cycle; go to RESP with err=1, data=0.
- Plain load goes to READ with tag NONE. Plain store goes to WRITE with tag NONE.
- Atomic requests, by funct5:
  - 00010 (LR): READ, tag LRSC, sel 1111.
  - 00011 (SC): WRITE, tag LRSC.
  - Otherwise (AMO): READ, tag AMO.
- Unknown funct5 for an atomic is treated as err, with no bus cycle.

**READ**
- `stb_o=cyc_o=1`, `we_o=0`.
- On `ack_i`, `data_i` is captured.
- Load/LR: go to RESP with data=`data_i`.
- AMO: register old=`data_i` and new=`amo_alu(funct5, old, rs2)`, then go to AMO_GAP.

**AMO_GAP**
- One cycle with `stb_o=0` and `cyc_o` held at 1. Then go to WRITE with data=new and tag AMO.

**WRITE**
- `stb_o=cyc_o=we_o=1`. On `ack_i`, go to RESP. Result data by request type:
  - store: 0;
  - SC: `{31'b0, data_tag_i}`;
  - AMO: the registered old value.

**RESP**
- `rsp_valid_o=1` for exactly one cycle, with `stb_o=cyc_o=0`. Then go to IDLE.

**AMO ALU** (signed/unsigned 32-bit compare, wrap-around add):
- ADD 00000, SWAP 00001, XOR 00100, OR 01000, AND 01100
- MIN 10000, MAX 10100, MINU 11000, MAXU 11100

**Bus waiting**
- The slave may withhold ack indefinitely, for example while an AMO lock is held at another address. The master keeps `stb_o` and all bus fields stable until ack.

## Timing
- Reset values: `req_ready_o=0` during reset and 1 the cycle after. All other outputs are 0, with `addr_tag_o`=`ADDR_TAG_NONE`.
- Reset mid-transaction: `stb_o`/`cyc_o` drop at the next edge and no `rsp_valid_o` is issued.
- `stb_o` rises in the cycle after acceptance. `ack_i` is sampled at every edge while `stb_o=1`, and `stb_o` falls in the cycle after the ack edge.
- Latency with a zero-wait slave (ack in the first stb cycle), from the accept edge to `rsp_valid_o`:
  - load, store, LR, SC: 2 cycles;
  - AMO: 4 cycles;
  - misaligned atomic: 1 cycle.
- `req_ready_o=0` from acceptance until the RESP cycle ends. Back-to-back requests are therefore spaced by at least one IDLE cycle.
- All bus outputs are registered. `ack_i` does not combinationally drive any output.

## Configuration
`MEM_ATOMIC_TIMEOUT_EN`
- **Defined:**
  - A 16-bit counter clears on each `stb_o` rise and increments while `stb_o & ~ack_i`.
  - When it reaches TIMEOUT_CYCLES, `stb_o`/`cyc_o` drop at the next edge and the block goes to RESP with err=1, data=0.
  - A timeout during an AMO write leaves the slave lock set and is fatal to software.
- **Undefined:** no counter and unbounded wait. `rsp_err_o` is raised only for misaligned or invalid atomics.

## Structure
- Package `mem_atomic_pkg`: state enum, kind localparams (LOAD/STORE/ATOMIC), funct5 localparams (LR, SC, AMO*).
- Tag values come from the shared `tags.svh`.
- Sub-module `amo_alu`: combinational, (funct5, a, b) -> result. It is instantiated once.

## Test plan
- **Zero-wait load:** addr 0x100, sel 1111, slave returns 0xDEADBEEF -> tag NONE, `rsp_data_o`=0xDEADBEEF, 2 cycles after accept.
- **LR then SC:** LR@0x200 (tag LRSC), then SC@0x200 data 0x5 with `data_tag_i=0` -> `rsp_data_o`=0. A repeat SC with `data_tag_i=1` -> `rsp_data_o`=1.
- **amoadd.w:** @0x300, memory 0x7FFFFFFF, rs2 1 -> read and write both tagged AMO, written 0x80000000, `rsp_data_o`=0x7FFFFFFF, `cyc_o` high across AMO_GAP.
- **amomin.w and amominu.w:** memory 0xFFFFFFFE, rs2 3 -> amomin writes 0xFFFFFFFE, amominu writes 0x3. Both respond with 0xFFFFFFFE.
- **Misaligned and stall:** amoswap @0x302 -> no `stb_o`, `rsp_err_o=1` after 1 cycle. Slave stalls ack 50 cycles -> `stb_o`, `addr_o`, `data_o` stable throughout. Reset asserted at cycle 20 -> `stb_o`=0 next edge, no response.
- **Timeout (with `MEM_ATOMIC_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** no ack -> `stb_o` falls after 8 cycles, `rsp_err_o=1`, `rsp_data_o`=0.

Source files
------------

// File: rtl/mem_atomic_pkg.sv
// mem_atomic_pkg
//   Shared types and constants for the CPU data-memory Wishbone initiator.
//   Contents:
//     - address-tag values driven toward the RAM bus reservation logic
//     - FSM state enum
//     - request kind codes (LOAD / STORE / ATOMIC)
//     - RV32A funct5 codes (LR, SC and the AMO operations)
//     - f5_is_known(): true for any funct5 the master can execute
package mem_atomic_pkg;

  // Address tag seen by the RAM bus: plain access, LR/SC reservation, AMO lock.
  localparam int         ADDR_TAG_BITS      = 2;
  localparam logic [1:0] ADDR_TAG_NONE      = 2'd0;
  localparam logic [1:0] ADDR_TAG_MODE_LRSC = 2'd1;
  localparam logic [1:0] ADDR_TAG_MODE_AMO  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_AMO_GAP = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] KIND_LOAD   = 2'd0;
  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_ATOMIC = 2'd2;

  localparam logic [4:0] F5_LR      = 5'b00010;
  localparam logic [4:0] F5_SC      = 5'b00011;
  localparam logic [4:0] F5_AMOADD  = 5'b00000;
  localparam logic [4:0] F5_AMOSWAP = 5'b00001;
  localparam logic [4:0] F5_AMOXOR  = 5'b00100;
  localparam logic [4:0] F5_AMOOR   = 5'b01000;
  localparam logic [4:0] F5_AMOAND  = 5'b01100;
  localparam logic [4:0] F5_AMOMIN  = 5'b10000;
  localparam logic [4:0] F5_AMOMAX  = 5'b10100;
  localparam logic [4:0] F5_AMOMINU = 5'b11000;
  localparam logic [4:0] F5_AMOMAXU = 5'b11100;

  function automatic logic f5_is_known(input logic [4:0] f5);
    logic known;
    case (f5)
      F5_LR, F5_SC, F5_AMOADD, F5_AMOSWAP, F5_AMOXOR, F5_AMOOR, F5_AMOAND,
      F5_AMOMIN, F5_AMOMAX, F5_AMOMINU, F5_AMOMAXU: known = 1'b1;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mem_atomic_master_amo_alu.sv
// amo_alu
//   Combinational RV32A read-modify-write operator.
//   Ports:
//     funct5 in  5   AMO operation code
//     a      in  32  old memory value
//     b      in  32  rs2 operand
//     result out 32  value to write back (wrap-around add, signed/unsigned min/max)
module amo_alu
  import mem_atomic_pkg::*;
(
  input  logic [4:0]  funct5,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = b;
    case (funct5)
      F5_AMOADD:  result = a + b;
      F5_AMOSWAP: result = b;
      F5_AMOXOR:  result = a ^ b;
      F5_AMOOR:   result = a | b;
      F5_AMOAND:  result = a & b;
      F5_AMOMIN:  result = ($signed(a) < $signed(b)) ? a : b;
      F5_AMOMAX:  result = ($signed(a) > $signed(b)) ? a : b;
      F5_AMOMINU: result = (a < b) ? a : b;
      F5_AMOMAXU: result = (a > b) ? a : b;
      default:    result = b;
    endcase
  end

endmodule

// File: rtl/mem_atomic_master.sv
// mem_atomic_master
//   Wishbone initiator for CPU data-memory requests including RV32A atomics.
//   One request becomes one bus cycle (load/store/LR/SC), two cycles for an AMO
//   (read, one-cycle gap with cyc held, write), or none for a misaligned or
//   unknown atomic, which responds with rsp_err_o.
//   Optional feature macro: MEM_ATOMIC_TIMEOUT_EN -- abandons a bus cycle after
//   TIMEOUT_CYCLES cycles without ack and responds with an error.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     req_valid_i / req_ready_o    request handshake
//     req_kind_i, req_funct5_i     0 load / 1 store / 2 atomic, RV32A funct5
//     req_addr_i, req_sel_i        byte address, byte select for load/store
//     req_data_i                   store data / rs2
//     rsp_valid_o, rsp_data_o      one-cycle result pulse and data
//     rsp_err_o                    misaligned/unknown atomic or bus timeout
//     stb_o, cyc_o, we_o, sel_o    Wishbone controls
//     addr_o, addr_tag_o, data_o   address, reservation tag, write data
//     ack_i, data_i, data_tag_i    slave ack, read data, SC-failed flag
//
//   Handshake: a request transfers on the rising edge where req_valid_i and
//   req_ready_o are both high; req_ready_o is high only in IDLE. rsp_valid_o
//   is a single-cycle pulse with no back-pressure.
module mem_atomic_master
  import mem_atomic_pkg::*;
#(
  parameter int CLK_PERIOD_NS  = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_kind_i,
  input  logic [4:0]               req_funct5_i,
  input  logic [31:0]              req_addr_i,
  input  logic [3:0]               req_sel_i,
  input  logic [31:0]              req_data_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  output logic                     we_o,
  output logic [3:0]               sel_o,
  output logic [31:0]              addr_o,
  output logic [ADDR_TAG_BITS-1:0] addr_tag_o,
  output logic [31:0]              data_o,
  input  logic                     ack_i,
  input  logic [31:0]              data_i,
  input  logic                     data_tag_i
);

  // Nonsensical configurations simply produce no logic here; the guard keeps
  // both parameters part of the elaborated design in every build.
  if (CLK_PERIOD_NS <= 0 || TIMEOUT_CYCLES <= 0) begin : g_param_guard
  end

  state_t      state, state_next;
  logic        ready_q;
  logic [31:0] addr_q, wdata_q, old_q, rsp_data_q;
  logic [3:0]  sel_q;
  logic [1:0]  tag_q, kind_q;
  logic [4:0]  funct5_q;
  logic        err_q;
  logic        accept, req_bad, req_is_atomic;
  logic        is_amo_q, is_sc_q;
  logic        tmo_hit;
  logic [31:0] amo_new;

  assign accept        = req_valid_i & ready_q;
  assign req_is_atomic = (req_kind_i == KIND_ATOMIC);
  // Kind 3 is not a defined request; it is rejected like a bad atomic.
  assign req_bad = (req_kind_i == 2'd3) |
                   (req_is_atomic & ((req_addr_i[1:0] != 2'b00) | !f5_is_known(req_funct5_i)));

  assign is_sc_q  = (kind_q == KIND_ATOMIC) & (funct5_q == F5_SC);
  assign is_amo_q = (kind_q == KIND_ATOMIC) & (funct5_q != F5_SC) & (funct5_q != F5_LR);

  // The operand b is the rs2 value still parked in wdata_q during READ.
  amo_alu u_amo_alu (
    .funct5 (funct5_q),
    .a      (data_i),
    .b      (wdata_q),
    .result (amo_new)
  );

`ifdef MEM_ATOMIC_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Cleared in the cycle before stb rises (accept or AMO gap) so each strobe
  // phase gets a full budget.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept || state == ST_AMO_GAP) begin
      tmo_cnt <= '0;
    end else if (stb_o && !ack_i) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = stb_o & ~ack_i & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_next = ST_RESP;
          end else if (req_kind_i == KIND_STORE ||
                       (req_is_atomic && req_funct5_i == F5_SC)) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (ack_i) begin
          state_next = is_amo_q ? ST_AMO_GAP : ST_RESP;
        end else if (tmo_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_AMO_GAP: state_next = ST_WRITE;
      ST_WRITE: begin
        if (ack_i || tmo_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    stb_o       = 1'b0;
    cyc_o       = 1'b0;
    we_o        = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_data_o  = '0;
    case (state)
      ST_READ: begin
        stb_o = 1'b1;
        cyc_o = 1'b1;
      end
      ST_AMO_GAP: cyc_o = 1'b1;
      ST_WRITE: begin
        stb_o = 1'b1;
        cyc_o = 1'b1;
        we_o  = 1'b1;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_data_o  = rsp_data_q;
      end
      default: ;
    endcase
  end

  assign req_ready_o = ready_q;
  assign sel_o       = sel_q;
  assign addr_o      = addr_q;
  assign addr_tag_o  = tag_q;
  assign data_o      = wdata_q;

  // Request capture and result datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      rsp_data_q <= '0;
      sel_q      <= '0;
      tag_q      <= ADDR_TAG_NONE;
      kind_q     <= KIND_LOAD;
      funct5_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= req_addr_i;
            wdata_q    <= req_data_i;
            kind_q     <= req_kind_i;
            funct5_q   <= req_funct5_i;
            err_q      <= req_bad;
            rsp_data_q <= '0;
            sel_q      <= req_is_atomic ? 4'b1111 : req_sel_i;
            if (!req_is_atomic || req_bad) begin
              tag_q <= ADDR_TAG_NONE;
            end else if (req_funct5_i == F5_LR || req_funct5_i == F5_SC) begin
              tag_q <= ADDR_TAG_MODE_LRSC;
            end else begin
              tag_q <= ADDR_TAG_MODE_AMO;
            end
          end
        end
        ST_READ: begin
          if (ack_i) begin
            rsp_data_q <= data_i;
            old_q      <= data_i;
            if (is_amo_q) begin
              wdata_q <= amo_new;
            end
          end else if (tmo_hit) begin
            err_q      <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        ST_WRITE: begin
          if (ack_i) begin
            if (is_sc_q) begin
              rsp_data_q <= {31'b0, data_tag_i};
            end else if (is_amo_q) begin
              rsp_data_q <= old_q;
            end else begin
              rsp_data_q <= '0;
            end
          end else if (tmo_hit) begin
            err_q      <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_atomic_master.sv
module tb_mem_atomic_master;

  localparam logic [1:0] K_LOAD = 2'd0, K_STORE = 2'd1, K_ATOM = 2'd2;
  localparam logic [1:0] T_NONE = 2'd0, T_LRSC = 2'd1, T_AMO = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = '0;
  logic [4:0]  req_funct5 = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [1:0]  addr_tag;
  logic        ack;
  logic [31:0] rd_val = '0;
  logic        sc_fail = 1'b0;

  mem_atomic_master #(.CLK_PERIOD_NS(20), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_kind_i(req_kind), .req_funct5_i(req_funct5),
    .req_addr_i(req_addr), .req_sel_i(req_sel), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .stb_o(stb), .cyc_o(cyc), .we_o(we), .sel_o(sel),
    .addr_o(addr), .addr_tag_o(addr_tag), .data_o(wdata),
    .ack_i(ack), .data_i(rd_val), .data_tag_i(sc_fail)
  );

  // slave: acks after wait_req stalled strobe cycles, combinationally from stb
  bit ack_en = 1'b1;
  int wait_req = 0;
  int wait_cnt = 0;
  assign ack = stb && ack_en && (wait_cnt >= wait_req);
  always @(posedge clk) begin
    if (stb && !ack) wait_cnt <= wait_cnt + 1;
    else             wait_cnt <= 0;
  end

  // bus log of completed beats
  logic        bus_we_q[$];
  logic [31:0] bus_addr_q[$];
  logic [31:0] bus_data_q[$];
  logic [1:0]  bus_tag_q[$];
  logic [3:0]  bus_sel_q[$];
  always @(posedge clk) begin
    if (!rst && stb && ack) begin
      bus_we_q.push_back(we);
      bus_addr_q.push_back(addr);
      bus_data_q.push_back(wdata);
      bus_tag_q.push_back(addr_tag);
      bus_sel_q.push_back(sel);
    end
  end

  // negedge monitors: strobe count, gap cycles, field stability while strobing
  int stb_cycles = 0, gap_cycles = 0, unstable = 0;
  logic        p_stb = 1'b0, p_we;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_sel;
  logic [1:0]  p_tag;
  always @(negedge clk) begin
    if (stb) stb_cycles++;
    if (cyc && !stb) gap_cycles++;
    if (stb && p_stb && !rst) begin
      if (we !== p_we || addr !== p_addr || wdata !== p_data || sel !== p_sel || addr_tag !== p_tag)
        unstable++;
    end
    p_stb = stb && !ack; p_we = we; p_addr = addr; p_data = wdata; p_sel = sel; p_tag = addr_tag;
  end

  int n_checks = 0;
  int n_fail = 0;

  // results of the last issue()
  bit          r_got;
  int          r_lat;
  logic [31:0] r_data;
  logic        r_err;

  logic [31:0] exp_q[$];

  task automatic clear_log();
    bus_we_q.delete(); bus_addr_q.delete(); bus_data_q.delete();
    bus_tag_q.delete(); bus_sel_q.delete();
  endtask

  // driver: waits for ready, transfers one request, waits for the response.
  // r_lat counts clock edges from the accept edge to the edge sampling rsp_valid.
  task automatic issue(input logic [1:0] kind, input logic [4:0] f5, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_kind = kind; req_funct5 = f5; req_addr = a; req_sel = s; req_data = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    r_lat = 1;
    while (!rsp_valid && r_lat < 400) begin @(negedge clk); r_lat++; end
    r_got = rsp_valid; r_data = rsp_data; r_err = rsp_err;
  endtask

  function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] m, input logic [31:0] r);
    int sm, sr;
    sm = m; sr = r;
    case (f)
      5'b00000: return m + r;
      5'b00001: return r;
      5'b00100: return m ^ r;
      5'b01000: return m | r;
      5'b01100: return m & r;
      5'b10000: return (sm <= sr) ? m : r;
      5'b10100: return (sm >= sr) ? m : r;
      5'b11000: return (m <= r) ? m : r;
      5'b11100: return (m >= r) ? m : r;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_checks++; if ({stb, cyc, we, rsp_valid, rsp_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {stb, cyc, we, rsp_valid, rsp_err}); end
    n_checks++; if ({addr, wdata, sel, rsp_data} !== 100'b0) begin n_fail++; $display("FAIL reset_fields: addr %h data %h sel %h rsp %h want 0", addr, wdata, sel, rsp_data); end
    n_checks++; if (addr_tag !== T_NONE) begin n_fail++; $display("FAIL reset_tag: got %0d want %0d", addr_tag, T_NONE); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
  endtask

  task automatic test_load();
    wait_req = 0; rd_val = 32'hDEADBEEF; clear_log();
    issue(K_LOAD, 5'd0, 32'h100, 4'b1111, 32'h0);
    n_checks++; if (!r_got || r_lat != 2) begin n_fail++; $display("FAIL load_latency: got %0d (resp %0d) want 2", r_lat, r_got); end
    n_checks++; if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin n_fail++; $display("FAIL load_data: got %h err %b want deadbeef err 0", r_data, r_err); end
    n_checks++; if (bus_we_q.size() != 1 || bus_we_q[0] !== 1'b0 || bus_addr_q[0] !== 32'h100 || bus_tag_q[0] !== T_NONE || bus_sel_q[0] !== 4'hF) begin
      n_fail++; $display("FAIL load_bus: beats %0d want one read @100 tag NONE sel f", bus_we_q.size()); end
  endtask

  task automatic test_store();
    logic [31:0] d;
    d = $urandom; wait_req = 0; clear_log();
    issue(K_STORE, 5'd0, 32'h120, 4'b0011, d);
    n_checks++; if (!r_got || r_lat != 2 || r_data !== 32'h0 || r_err !== 1'b0) begin n_fail++; $display("FAIL store_rsp: lat %0d data %h err %b want 2 0 0", r_lat, r_data, r_err); end
    n_checks++; if (bus_we_q.size() != 1 || bus_we_q[0] !== 1'b1 || bus_data_q[0] !== d || bus_sel_q[0] !== 4'b0011 || bus_tag_q[0] !== T_NONE) begin
      n_fail++; $display("FAIL store_bus: beats %0d want one write of %h sel 3", bus_we_q.size(), d); end
  endtask

  task automatic test_lrsc();
    wait_req = 0; rd_val = 32'h0000_1234; clear_log();
    issue(K_ATOM, 5'b00010, 32'h200, 4'b0001, 32'h0);
    n_checks++; if (!r_got || r_lat != 2 || r_data !== 32'h1234) begin n_fail++; $display("FAIL lr_rsp: lat %0d data %h want 2 00001234", r_lat, r_data); end
    n_checks++; if (bus_we_q.size() != 1 || bus_we_q[0] !== 1'b0 || bus_tag_q[0] !== T_LRSC || bus_sel_q[0] !== 4'hF) begin
      n_fail++; $display("FAIL lr_bus: beats %0d want one read tag LRSC sel f", bus_we_q.size()); end
    clear_log(); sc_fail = 1'b0;
    issue(K_ATOM, 5'b00011, 32'h200, 4'b0000, 32'h5);
    n_checks++; if (!r_got || r_lat != 2 || r_data !== 32'h0) begin n_fail++; $display("FAIL sc_ok: lat %0d data %h want 2 0", r_lat, r_data); end
    n_checks++; if (bus_we_q.size() != 1 || bus_we_q[0] !== 1'b1 || bus_data_q[0] !== 32'h5 || bus_tag_q[0] !== T_LRSC) begin
      n_fail++; $display("FAIL sc_bus: beats %0d want one write of 5 tag LRSC", bus_we_q.size()); end
    sc_fail = 1'b1;
    issue(K_ATOM, 5'b00011, 32'h200, 4'b0000, 32'h5);
    n_checks++; if (!r_got || r_data !== 32'h1) begin n_fail++; $display("FAIL sc_fail: data %h want 1", r_data); end
    sc_fail = 1'b0;
  endtask

  task automatic test_amo(input logic [4:0] f5, input logic [31:0] mem, input logic [31:0] rs2,
                          input logic [31:0] exp_w);
    wait_req = 0; rd_val = mem; clear_log(); gap_cycles = 0;
    issue(K_ATOM, f5, 32'h300, 4'b0000, rs2);
    n_checks++; if (!r_got || r_lat != 4 || r_data !== mem || r_err !== 1'b0) begin
      n_fail++; $display("FAIL amo_rsp f5=%b: lat %0d data %h err %b want 4 %h 0", f5, r_lat, r_data, r_err, mem); end
    n_checks++; if (bus_we_q.size() != 2 || bus_we_q[0] !== 1'b0 || bus_we_q[1] !== 1'b1 || bus_tag_q[0] !== T_AMO || bus_tag_q[1] !== T_AMO || bus_data_q[1] !== exp_w) begin
      n_fail++; $display("FAIL amo_bus f5=%b: beats %0d wdata %h want read+write of %h tag AMO", f5, bus_we_q.size(), (bus_data_q.size() > 1) ? bus_data_q[1] : 32'hx, exp_w); end
    n_checks++; if (gap_cycles != 1) begin n_fail++; $display("FAIL amo_gap: got %0d cyc-only cycles want 1", gap_cycles); end
  endtask

  task automatic test_misaligned();
    clear_log(); stb_cycles = 0;
    issue(K_ATOM, 5'b00001, 32'h302, 4'b0000, 32'h9);
    n_checks++; if (!r_got || r_lat != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL misaligned: lat %0d err %b data %h want 1 1 0", r_lat, r_err, r_data); end
    issue(K_ATOM, 5'b00101, 32'h304, 4'b0000, 32'h9);
    n_checks++; if (!r_got || r_lat != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL bad_funct5: lat %0d err %b data %h want 1 1 0", r_lat, r_err, r_data); end
    n_checks++; if (stb_cycles != 0 || bus_we_q.size() != 0) begin n_fail++; $display("FAIL err_no_bus: stb cycles %0d beats %0d want 0 0", stb_cycles, bus_we_q.size()); end
  endtask

  task automatic test_stall();
    wait_req = 50; clear_log(); unstable = 0;
    issue(K_STORE, 5'd0, 32'h440, 4'b1111, 32'hCAFE_F00D);
    n_checks++; if (!r_got || r_lat != 52) begin n_fail++; $display("FAIL stall_latency: got %0d want 52", r_lat); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL stall_stable: %0d changed cycles want 0", unstable); end
    n_checks++; if (bus_data_q.size() != 1 || bus_data_q[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stall_bus: beats %0d want one write of cafef00d", bus_data_q.size()); end
    wait_req = 0;
  endtask

  task automatic test_reset_mid();
    int seen;
    ack_en = 1'b0; seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_kind = K_LOAD; req_addr = 32'h500; req_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: stb %b want 1", stb); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (stb !== 1'b0 || cyc !== 1'b0) begin n_fail++; $display("FAIL midreset_drop: stb %b cyc %b want 0 0", stb, cyc); end
    ack_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_rsp: %0d responses ready %b want 0 1", seen, req_ready); end
  endtask

`ifdef MEM_ATOMIC_TIMEOUT_EN
  task automatic test_timeout();
    ack_en = 1'b0; stb_cycles = 0;
    issue(K_LOAD, 5'd0, 32'h600, 4'hF, 32'h0);
    n_checks++; if (!r_got || r_err !== 1'b1 || r_data !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp: got %0d err %b data %h want 1 1 0", r_got, r_err, r_data); end
    n_checks++; if (stb_cycles != 8) begin n_fail++; $display("FAIL timeout_len: stb cycles %0d want 8", stb_cycles); end
    ack_en = 1'b1;
  endtask
`endif

  // randomized back-to-back traffic checked against a memory model
  task automatic test_back_to_back();
    logic [31:0] mem [logic [31:0]];
    logic [4:0]  amo_ops [9] = '{5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                                 5'b10000, 5'b10100, 5'b11000, 5'b11100};
    for (int n = 0; n < 40; n++) begin
      int          op, w, exp_lat;
      logic [31:0] a, d, m, exp_w;
      logic [4:0]  f5;
      logic [1:0]  kind;
      bit          writes;
      op = $urandom_range(0, 4); w = $urandom_range(0, 3);
      a = 32'h1000 + 32'($urandom_range(0, 3)) * 4; d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'h8000_0000 | d;
      m = mem.exists(a) ? mem[a] : 32'h0;
      rd_val = m; wait_req = w; sc_fail = 1'($urandom_range(0, 1));
      f5 = 5'd0; kind = K_LOAD; writes = 1'b0; exp_w = 32'h0; exp_lat = 2 + w;
      case (op)
        0: begin exp_q.push_back(m); end
        1: begin kind = K_STORE; writes = 1'b1; exp_w = d; mem[a] = d; exp_q.push_back(32'h0); end
        2: begin kind = K_ATOM; f5 = 5'b00010; exp_q.push_back(m); end
        3: begin kind = K_ATOM; f5 = 5'b00011; writes = 1'b1; exp_w = d;
                 if (!sc_fail) mem[a] = d; exp_q.push_back({31'b0, sc_fail}); end
        default: begin kind = K_ATOM; f5 = amo_ops[$urandom_range(0, 8)]; writes = 1'b1;
                 exp_w = amo_ref(f5, m, d); mem[a] = exp_w; exp_lat = 4 + 2 * w; exp_q.push_back(m); end
      endcase
      clear_log();
      issue(kind, f5, a, 4'hF, d);
      n_checks++; if (!r_got || r_data !== exp_q.pop_front() || r_err !== 1'b0 || r_lat != exp_lat) begin
        n_fail++; $display("FAIL rand_rsp #%0d op %0d: data %h err %b lat %0d want lat %0d", n, op, r_data, r_err, r_lat, exp_lat); end
      if (writes) begin
        n_checks++; if (bus_data_q.size() == 0 || bus_data_q[$] !== exp_w || bus_we_q[$] !== 1'b1) begin
          n_fail++; $display("FAIL rand_write #%0d op %0d: wrote %h want %h", n, op, (bus_data_q.size() > 0) ? bus_data_q[$] : 32'hx, exp_w); end
      end
    end
    wait_req = 0; sc_fail = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_lrsc();
    test_amo(5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    test_amo(5'b10000, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFE);
    test_amo(5'b11000, 32'hFFFF_FFFE, 32'h3, 32'h0000_0003);
    test_misaligned();
    test_stall();
    test_reset_mid();
`ifdef MEM_ATOMIC_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
